// File: rtl/mtsp_gmb_arb_pkg.sv
// rtl/mtsp_gmb_arb_pkg.sv - shared types and round-robin pick for the GMB arbiter
package mtsp_gmb_arb_pkg;

  localparam int MAX_REQ  = 8;
  localparam int ID_WIDTH = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  // First set bit of mask at or above ptr, wrapping within the lowest n bits.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  mask,
    input logic [ID_WIDTH-1:0] ptr,
    input int                  n
  );
    logic [MAX_REQ-1:0] onehot;
    logic               found;
    int                 idx;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && mask[idx[ID_WIDTH-1:0]]) begin
        onehot[idx[ID_WIDTH-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/mtsp_gmb_tag_pipe.sv
// rtl/mtsp_gmb_tag_pipe.sv - read-tag shift register predicting GMB output-enable
module mtsp_gmb_tag_pipe
  import mtsp_gmb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  tag_t                push_tag,
  output logic                exp_oe,
  output logic [ID_WIDTH-1:0] tail_id,
  output logic                any_valid
);

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign exp_oe  = stage_q[DEPTH-1].valid;
  assign tail_id = stage_q[DEPTH-1].id;

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage_q[i].valid;
  end

endmodule

// File: rtl/mtsp_gmb_arbiter.sv
// rtl/mtsp_gmb_arbiter.sv - round-robin GMB arbiter with burst lock and read-return routing
module mtsp_gmb_arbiter
  import mtsp_gmb_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 256,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          EN,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic [NUM_REQ-1:0]            REQ_WE,
  input  logic [NUM_REQ-1:0]            REQ_LOCK,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DIN,
  output logic                          GMB_CE,
  output logic                          GMB_WE,
  output logic [ADDR_WIDTH-1:0]         GMB_ADDR,
  output logic [DATA_WIDTH-1:0]         GMB_DIN,
  input  logic                          GMB_OE,
  input  logic [DATA_WIDTH-1:0]         GMB_DOUT,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  output logic                          BUSY,
  output logic                          ERR_OE
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [MAX_REQ-1:0]  rr_onehot;
  logic [NUM_REQ-1:0]  grant;
  logic [PTR_W-1:0]    win_idx;
  logic                grant_any;
  logic                owner_valid;
  logic                burst_hold;
  tag_t                cmd_tag;
  logic                exp_oe;
  logic [ID_WIDTH-1:0] tail_id;
  logic                tags_busy;
  logic [NUM_REQ-1:0]  rsp_onehot;

  assign rr_onehot = rr_pick(MAX_REQ'(REQ_VALID), ID_WIDTH'(ptr_q), NUM_REQ);

  generate
    if (NUM_REQ < MAX_REQ) begin : g_rr_pad
      logic unused_rr_hi;
      assign unused_rr_hi = ^rr_onehot[MAX_REQ-1:NUM_REQ];
    end
  endgenerate

  assign owner_valid = REQ_VALID[owner_q];
  assign burst_hold  = (state_q == BURST) && owner_valid;
  assign cnt_inc     = cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // A vanished owner ends the burst and lets normal arbitration pick in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant_any) begin
      ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      if (burst_hold) begin
        cnt_d = cnt_inc;
        if (!REQ_LOCK[win_idx] || (cnt_inc >= CNT_W'(MAX_BURST))) state_d = IDLE;
      end else if (REQ_LOCK[win_idx] && (MAX_BURST > 1)) begin
        state_d = BURST;
        owner_d = win_idx;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end else if ((state_q == BURST) && EN && !owner_valid) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    grant = '0;
    if (EN) begin
      if (burst_hold) grant[owner_q] = 1'b1;
      else            grant = rr_onehot[NUM_REQ-1:0];
    end
  end

  assign REQ_READY = grant;
  assign grant_any = |grant;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      GMB_CE   <= 1'b0;
      GMB_WE   <= 1'b0;
      GMB_ADDR <= '0;
      GMB_DIN  <= '0;
      cmd_tag  <= '0;
    end else if (grant_any) begin
      GMB_CE        <= 1'b1;
      GMB_WE        <= REQ_WE[win_idx];
      GMB_ADDR      <= REQ_ADDR[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      GMB_DIN       <= REQ_DIN[win_idx*DATA_WIDTH +: DATA_WIDTH];
      cmd_tag.valid <= ~REQ_WE[win_idx];
      cmd_tag.id    <= ID_WIDTH'(win_idx);
    end else begin
      GMB_CE  <= 1'b0;
      cmd_tag <= '0;
    end
  end

  mtsp_gmb_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clk      (CLK),
    .rst_n    (nRST),
    .push_tag (cmd_tag),
    .exp_oe   (exp_oe),
    .tail_id  (tail_id),
    .any_valid(tags_busy)
  );

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) rsp_onehot[i] = (tail_id == ID_WIDTH'(i));
  end

  // Any OE that disagrees with the tag pipe is sticky; a stray OE never reaches a requester.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      RSP_VALID <= '0;
      RSP_DATA  <= '0;
      ERR_OE    <= 1'b0;
    end else begin
      ERR_OE <= ERR_OE | (GMB_OE ^ exp_oe);
      if (GMB_OE && exp_oe) begin
        RSP_VALID <= rsp_onehot;
        RSP_DATA  <= GMB_DOUT;
      end else begin
        RSP_VALID <= '0;
      end
    end
  end

  assign BUSY = GMB_CE | tags_busy | (|RSP_VALID);

endmodule

// File: tb/tb_mtsp_gmb_arbiter.sv
// tb/tb_mtsp_gmb_arbiter.sv - randomized reference-model bench for mtsp_gmb_arbiter
module tb_mtsp_gmb_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 256;
  localparam int RL = 2;
  localparam int MB = 4;

  logic            CLK, nRST, EN;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_din;
  logic            GMB_CE, GMB_WE, GMB_OE, BUSY, ERR_OE;
  logic [AW-1:0]   GMB_ADDR;
  logic [DW-1:0]   GMB_DIN, GMB_DOUT, RSP_DATA;
  logic [N-1:0]    RSP_VALID;

  mtsp_gmb_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_BURST(MB)
  ) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we), .REQ_LOCK(req_lock),
    .REQ_ADDR(req_addr), .REQ_DIN(req_din),
    .GMB_CE(GMB_CE), .GMB_WE(GMB_WE), .GMB_ADDR(GMB_ADDR), .GMB_DIN(GMB_DIN),
    .GMB_OE(GMB_OE), .GMB_DOUT(GMB_DOUT),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY), .ERR_OE(ERR_OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: arbitration state as plain integers, expectations keyed by cycle.
  int  m_ptr, m_owner, m_cnt;
  bit  m_burst;
  int  cyc;
  bit  err_exp;
  logic [N-1:0] rdy_seen;
  int  g_hist[$];

  bit              ce_exp[int];
  bit              we_exp[int];
  logic [AW-1:0]   addr_exp[int];
  logic [DW-1:0]   din_exp[int];
  bit              rd_cmd_exp[int];
  int              rsp_id_exp[int];
  logic [DW-1:0]   rsp_data_exp[int];
  bit              oe_sched[int];
  logic [DW-1:0]   dout_sched[int];
  logic [DW-1:0]   ref_mem[int];
  logic [DW-1:0]   gmb_mem[int];

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int model_pick();
    if (!EN) return -1;
    if (m_burst && req_valid[m_owner]) return m_owner;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (m_burst && g == m_owner) begin
        m_cnt++;
        if (!req_lock[g] || m_cnt >= MB) m_burst = 0;
      end else if (req_lock[g] && MB > 1) begin
        m_burst = 1;
        m_owner = g;
        m_cnt   = 1;
      end else begin
        m_burst = 0;
      end
    end else if (m_burst && EN && !req_valid[m_owner]) begin
      m_burst = 0;
    end
  endtask

  task automatic step();
    int            g, a;
    logic [N-1:0]  exp_ready, exp_rv;
    bit            busy_exp;
    #1;
    g = model_pick();
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    check_eq("ready", req_ready, exp_ready);
    check_eq("gmb_ce", GMB_CE, ce_exp.exists(cyc));
    if (ce_exp.exists(cyc)) begin
      check_eq("gmb_we", GMB_WE, we_exp[cyc]);
      check_eq("gmb_addr", GMB_ADDR, addr_exp[cyc]);
      check_eq("gmb_din", GMB_DIN, din_exp[cyc]);
    end
    exp_rv = rsp_id_exp.exists(cyc) ? (N'(1) << rsp_id_exp[cyc]) : '0;
    check_eq("rsp_valid", RSP_VALID, exp_rv);
    if (rsp_id_exp.exists(cyc)) check_eq("rsp_data", RSP_DATA, rsp_data_exp[cyc]);
    check_eq("err_oe", ERR_OE, err_exp);
    busy_exp = ce_exp.exists(cyc) || rsp_id_exp.exists(cyc);
    for (int k = 1; k <= RL; k++) if (rd_cmd_exp.exists(cyc - k)) busy_exp = 1;
    check_eq("busy", BUSY, busy_exp);
    // GMB memory model services whatever command is on the bus this cycle
    if (GMB_CE) begin
      if (GMB_WE) gmb_mem[int'(GMB_ADDR)] = GMB_DIN;
      else begin
        oe_sched[cyc + RL]   = 1;
        dout_sched[cyc + RL] = gmb_mem.exists(int'(GMB_ADDR)) ? gmb_mem[int'(GMB_ADDR)] : '0;
      end
    end
    if (g >= 0) begin
      a = int'(req_addr[g*AW +: AW]);
      ce_exp[cyc + 1]   = 1;
      we_exp[cyc + 1]   = req_we[g];
      addr_exp[cyc + 1] = req_addr[g*AW +: AW];
      din_exp[cyc + 1]  = req_din[g*DW +: DW];
      if (req_we[g]) ref_mem[a] = req_din[g*DW +: DW];
      else begin
        rd_cmd_exp[cyc + 1]        = 1;
        rsp_id_exp[cyc + RL + 2]   = g;
        rsp_data_exp[cyc + RL + 2] = ref_mem.exists(a) ? ref_mem[a] : '0;
      end
    end
    model_update(g);
    g_hist.push_back(g);
    rdy_seen = req_ready;
    @(posedge CLK);
    #1;
    cyc++;
    GMB_OE   = oe_sched.exists(cyc);
    GMB_DOUT = oe_sched.exists(cyc) ? dout_sched[cyc] : rand256();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    EN = 1'b0;
    req_valid = '0;
    req_lock = '0;
    req_we = '0;
    GMB_OE = 1'b0;
    #1;
    check_eq("rst_ce", GMB_CE, 0);
    check_eq("rst_we", GMB_WE, 0);
    check_eq("rst_addr", GMB_ADDR, 0);
    check_eq("rst_din", GMB_DIN, 0);
    check_eq("rst_rsp_valid", RSP_VALID, 0);
    check_eq("rst_rsp_data", RSP_DATA, 0);
    check_eq("rst_err", ERR_OE, 0);
    check_eq("rst_busy", BUSY, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    ce_exp.delete(); we_exp.delete(); addr_exp.delete(); din_exp.delete();
    rd_cmd_exp.delete(); rsp_id_exp.delete(); rsp_data_exp.delete();
    oe_sched.delete(); dout_sched.delete(); g_hist.delete();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 0;
    err_exp = 0; rdy_seen = '0; cyc = 0;
  endtask

  task automatic new_beat(input int i, input bit lock_en);
    req_valid[i] = 1'b1;
    req_we[i]    = ($urandom_range(0, 2) == 0);
    req_lock[i]  = lock_en && ($urandom_range(0, 99) < 40);
    req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
    req_din[i*DW +: DW]  = rand256();
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  int           grants [N];
  int           b_beats;
  bit           r_done;
  int           exp_seq3 [6] = '{2, 2, 2, 2, 0, 2};
  int           exp_seq4 [3] = '{3, 3, 1};
  logic [N-1:0] t1_rv = 4'b0010;

  initial begin
    nRST = 1'b0; EN = 1'b0; req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_din = '0; GMB_OE = 1'b0; GMB_DOUT = '0;
    @(posedge CLK);
    #1;
    do_reset();

    // Single read by requester 1
    gmb_mem[16] = {32{8'hA5}};
    ref_mem[16] = {32{8'hA5}};
    EN = 1'b1;
    req_valid = 4'b0010;
    req_we = '0;
    req_addr[1*AW +: AW] = 12'h010;
    step();
    req_valid = '0;
    step(); step(); step();
    check_eq("t1_rsp_valid", RSP_VALID, t1_rv);
    check_eq("t1_rsp_data", RSP_DATA, {32{8'hA5}});
    idle(4);

    // Fairness with all requesters continuously valid
    do_reset();
    EN = 1'b1;
    for (int i = 0; i < N; i++) grants[i] = 0;
    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i] || rdy_seen[i]) new_beat(i, 1'b0);
      step();
      for (int i = 0; i < N; i++) if (rdy_seen[i]) grants[i]++;
    end
    for (int i = 0; i < N; i++) check_eq($sformatf("fair_cnt%0d", i), grants[i], 25);
    idle(6);

    // Burst cap: requester 2 locks six beats against requester 0
    do_reset();
    EN = 1'b1;
    b_beats = 0;
    r_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (rdy_seen[2]) b_beats++;
      if (rdy_seen[0]) r_done = 1;
      req_valid[2] = (b_beats < 6);
      req_lock[2]  = 1'b1;
      req_we[2]    = 1'b0;
      req_addr[2*AW +: AW] = AW'(b_beats);
      req_valid[0] = (c >= 1) && !r_done;
      req_lock[0]  = 1'b0;
      req_we[0]    = 1'b0;
      step();
    end
    for (int k = 0; k < 6; k++) check_eq($sformatf("burst_seq%0d", k), g_hist[k], exp_seq3[k]);
    idle(6);

    // Early burst end: requester 3 drops valid after two locked beats
    do_reset();
    EN = 1'b1;
    b_beats = 0;
    r_done = 0;
    for (int c = 0; c < 5; c++) begin
      if (rdy_seen[3]) b_beats++;
      if (rdy_seen[1]) r_done = 1;
      req_valid[3] = (b_beats < 2);
      req_lock[3]  = 1'b1;
      req_we[3]    = 1'b0;
      req_valid[1] = (c >= 1) && !r_done;
      req_lock[1]  = 1'b0;
      req_we[1]    = 1'b1;
      step();
    end
    for (int k = 0; k < 3; k++) check_eq($sformatf("early_seq%0d", k), g_hist[k], exp_seq4[k]);
    idle(6);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || rdy_seen[i]) begin
          if ($urandom_range(0, 99) < 60) new_beat(i, 1'b1);
          else req_valid[i] = 1'b0;
        end
      end
      EN = ($urandom_range(0, 9) != 0);
      step();
    end
    EN = 1'b1;
    idle(8);

    // Unexpected OE with nothing in flight
    do_reset();
    step();
    GMB_OE = 1'b1;
    step();
    err_exp = 1;
    for (int k = 0; k < 4; k++) step();

    // Reset one cycle after a read grant drops the read
    do_reset();
    EN = 1'b1;
    req_valid = 4'b0001;
    req_we = '0;
    req_addr[0 +: AW] = 12'h003;
    step();
    req_valid = '0;
    check_eq("t6_ce_before_rst", GMB_CE, 1);
    do_reset();
    GMB_OE = 1'b1;
    step();
    err_exp = 1;
    for (int k = 0; k < 4; k++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mtsp_gmb_arbiter.md
Name: mtsp_gmb_arbiter

Overview:
- Round-robin arbiter sharing the single-ported global memory buffer (GMB: 2-cycle read latency, 256-bit words) between NUM_REQ stream-processor requesters.
- Accepts per-requester read/write commands with valid/ready, optionally locks short bursts, and issues one registered command per cycle to the GMB.
- Tracks in-flight reads and routes each returned word to its originator, checking that GMB output-enable pulses match expectation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 12, GMB word address width.
- DATA_WIDTH, 256, data width (one DWORDx8).
- READ_LATENCY, 2, cycles from GMB command to GMB output-enable.
- MAX_BURST, 4, maximum consecutive locked grants to one requester (≥1).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- EN  in  1  arbitration enable; 0 = grant nothing
- REQ_VALID  in  NUM_REQ  command valid per requester
- REQ_READY  out  NUM_REQ  one-hot grant, combinational
- REQ_WE  in  NUM_REQ  1 = write, 0 = read
- REQ_LOCK  in  NUM_REQ  request to keep grant for the next beat
- REQ_ADDR  in  NUM_REQ×ADDR_WIDTH  packed addresses
- REQ_DIN  in  NUM_REQ×DATA_WIDTH  packed write data
- GMB_CE, GMB_WE  out  1 each  registered GMB chip/write enable
- GMB_ADDR  out  ADDR_WIDTH  registered GMB address
- GMB_DIN  out  DATA_WIDTH  registered GMB write data
- GMB_OE  in  1  GMB read-data valid
- GMB_DOUT  in  DATA_WIDTH  GMB read data
- RSP_VALID  out  NUM_REQ  one-hot read-return strobe
- RSP_DATA  out  DATA_WIDTH  read data, shared by all requesters
- BUSY  out  1  command or read in flight
- ERR_OE  out  1  sticky protocol error

Behaviour:
- Reset (async, nRST=0) values:
  - GMB_CE=0, GMB_WE=0, GMB_ADDR=0, GMB_DIN=0.
  - RSP_VALID=0, RSP_DATA=0, ERR_OE=0, BUSY=0.
  - Pointer=0, state=IDLE, tag pipe cleared.
  - In-flight reads are dropped; no response is issued after reset.
- Handshake:
  - A beat transfers when REQ_VALID[i]&REQ_READY[i].
  - Requesters hold WE/ADDR/DIN/LOCK stable while valid and not ready.
  - REQ_READY depends only on REQ_VALID, EN, state, pointer and owner. It never depends on REQ_READY itself.
- Arbitration, state IDLE:
  - When EN=1, the first valid requester scanning from pointer upward (mod NUM_REQ) is granted.
  - After a grant to i, pointer=(i+1) mod NUM_REQ.
  - If the granted beat has REQ_LOCK=1 and MAX_BURST>1, go to BURST with owner=i and beat count=1.
- State BURST:
  - Only the owner may be granted.
  - If the owner is valid and EN=1, it is granted and count increments.
  - The burst ends (go to IDLE) when any of these holds:
    - the granted beat has LOCK=0;
    - count reaches MAX_BURST;
    - the owner is not valid; in this case normal IDLE arbitration runs in the same cycle.
  - EN=0 in BURST stalls without leaving the state.
- Command stage:
  - On a grant, next cycle GMB_CE=1, GMB_WE=REQ_WE[i], GMB_ADDR, GMB_DIN are registered from the winner. Otherwise GMB_CE=0 and the other outputs hold.
  - Maximum throughput is one command per cycle.
- Read tracking:
  - Each issued read pushes {valid=1, id} into a READ_LATENCY-deep shift register aligned with GMB_CE. Writes and idle cycles push valid=0.
  - Expected OE = tail valid.
- Response:
  - On GMB_OE=1 with expected OE, the next cycle drives RSP_VALID=onehot(tail id) and RSP_DATA=GMB_DOUT.
  - Otherwise RSP_VALID=0 and RSP_DATA holds.
  - End-to-end read latency is grant cycle + READ_LATENCY + 2.
- Error:
  - GMB_OE differing from expected OE in any cycle sets ERR_OE. Only reset clears it.
  - An unexpected OE produces no RSP_VALID. A missing OE drops that response.
- BUSY = GMB_CE | any tag valid | any RSP_VALID.
- A read and a write from different requesters to the same address are ordered strictly by grant order. The GMB provides no forwarding.

Decomposition:
- Shared package mtsp_gmb_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the tag struct {logic valid; logic [$clog2(NUM_REQ)-1:0] id};
  - a round-robin pick function (mask, pointer → one-hot).
- One natural sub-module, mtsp_gmb_tag_pipe: a parameterised READ_LATENCY-deep tag shift register with an expected-OE output.

Test Plan:
1. Single read: req1 reads addr 0x010 at cycle 0, GMB model returns 0xA5…A5 → GMB_CE at cycle 1; RSP_VALID=4'b0010 with data 0xA5…A5 at cycle 4; BURST stays IDLE.
2. Fairness: all 4 requesters valid continuously, no lock, pointer=0 → grants in order 0,1,2,3,0,… with GMB_CE high every cycle; each requester gets exactly 25 of 100 grants.
3. Burst cap: req2 asserts LOCK on 6 beats while req0 is also valid, MAX_BURST=4 → req2 granted 4 consecutive cycles, then req0, then req2 resumes.
4. Early burst end: req3 locks, then drops VALID after 2 beats while req1 is valid → req1 is granted in the same cycle req3 drops; state returns to IDLE.
5. OE fault: force GMB_OE=1 with no read in flight → ERR_OE=1 next cycle, no RSP_VALID; ERR_OE persists until nRST=0.
6. Reset mid-read: assert nRST=0 one cycle after a read grant → all outputs 0 immediately; no RSP_VALID after reset release even if GMB_OE pulses (ERR_OE then set).
